// File: rtl/exp6_controle_rodadas_pkg.sv
// Shared state codes for the round-control FSM of the memory game.
// Imported by the FSM, debug decoders and benches so codes never diverge.
package exp6_controle_rodadas_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        FIM_RODADA     = 4'h7,
        PERDE_VIDA     = 4'h8,
        FINAL_ACERTO   = 4'h9,
        FINAL_ERRO     = 4'hA,
        FINAL_TIMEOUT  = 4'hF
    } estado_t;

    function automatic logic eh_final(estado_t e);
        return (e == FINAL_ACERTO) || (e == FINAL_ERRO) ||
               (e == FINAL_TIMEOUT);
    endfunction

endpackage

// File: rtl/exp6_controle_rodadas_contador_m.sv
// Generic modulo-M counter with sync clear, enable and end-of-count flag.
// Ports: clock, reset (async, low), clear, enable -> fim (count == M-1).
module contador_m #(
    parameter int M = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    localparam int QW = (M > 1) ? $clog2(M) : 1;
    localparam logic [QW-1:0] ULT = QW'(M - 1);

    logic [QW-1:0] q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= (q == ULT) ? '0 : q + QW'(1);
        end
    end

    assign fim = (q == ULT);

endmodule

// File: rtl/exp6_controle_rodadas.sv
// Round-control FSM for the memory game: rounds, plays, lives, timeout.
// In: clock, reset, iniciar, modo, jogada, igual. Out: endereco, rodada,
// zeraR, registraR, vidas, acertou, errou, pronto, db_timeout, db_estado.
module exp6_controle_rodadas
    import exp6_controle_rodadas_pkg::*;
#(
    parameter int N_RODADAS      = 16,
    parameter int N_CURTO        = 4,
    parameter int N_VIDAS        = 3,
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iniciar,
    input  logic                         modo,
    input  logic                         jogada,
    input  logic                         igual,
    output logic [$clog2(N_RODADAS)-1:0] endereco,
    output logic [$clog2(N_RODADAS)-1:0] rodada,
    output logic                         zeraR,
    output logic                         registraR,
    output logic [2:0]                   vidas,
    output logic                         acertou,
    output logic                         errou,
    output logic                         pronto,
    output logic                         db_timeout,
    output logic [3:0]                   db_estado
);

    localparam int W = $clog2(N_RODADAS);
    localparam logic [W-1:0] ULT_NORMAL = W'(N_RODADAS - 1);
    localparam logic [W-1:0] ULT_CURTO  = W'(N_CURTO - 1);
    localparam logic [W-1:0] UM         = W'(1);

    estado_t        estado;
    logic           modo_r;
    logic           fim_tempo;
    logic           timeout;
    logic [W-1:0]   ultima;

    // Last round index, fixed by the mode latched at game start.
    assign ultima  = modo_r ? ULT_CURTO : ULT_NORMAL;
    assign timeout = (estado == ESPERA) && fim_tempo;

    contador_m #(
        .M (TIMEOUT_CICLOS)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  ((estado == INICIO_RODADA) ||
                 (estado == PROXIMA_JOGADA)),
        .enable (estado == ESPERA),
        .fim    (fim_tempo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            endereco <= '0;
            rodada   <= '0;
            vidas    <= '0;
            modo_r   <= 1'b0;
        end else begin
            case (estado)
                INICIAL: begin
                    if (iniciar) estado <= PREPARACAO;
                end
                PREPARACAO: begin
                    rodada   <= '0;
                    endereco <= '0;
                    vidas    <= 3'(N_VIDAS);
                    modo_r   <= modo;
                    estado   <= INICIO_RODADA;
                end
                INICIO_RODADA: begin
                    endereco <= '0;
                    estado   <= ESPERA;
                end
                ESPERA: begin
                    // Timeout has priority over a play in the same cycle.
                    if (timeout)     estado <= FINAL_TIMEOUT;
                    else if (jogada) estado <= REGISTRA;
                end
                REGISTRA: begin
                    estado <= COMPARACAO;
                end
                COMPARACAO: begin
                    if (!igual)
                        estado <= (vidas > 3'd1) ? PERDE_VIDA : FINAL_ERRO;
                    else if (endereco < rodada)
                        estado <= PROXIMA_JOGADA;
                    else if (rodada == ultima)
                        estado <= FINAL_ACERTO;
                    else
                        estado <= FIM_RODADA;
                end
                PROXIMA_JOGADA: begin
                    endereco <= endereco + UM;
                    estado   <= ESPERA;
                end
                FIM_RODADA: begin
                    rodada <= rodada + UM;
                    estado <= INICIO_RODADA;
                end
                PERDE_VIDA: begin
                    // Same round is replayed from its first play.
                    vidas  <= vidas - 3'd1;
                    estado <= INICIO_RODADA;
                end
                FINAL_ACERTO, FINAL_ERRO, FINAL_TIMEOUT: begin
                    if (iniciar) estado <= PREPARACAO;
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

    assign db_estado  = estado;
    assign zeraR      = (estado == PREPARACAO) ||
                        (estado == INICIO_RODADA);
    assign registraR  = (estado == REGISTRA);
    assign acertou    = (estado == FINAL_ACERTO);
    assign errou      = (estado == FINAL_ERRO);
    assign db_timeout = (estado == FINAL_TIMEOUT);
    assign pronto     = eh_final(estado);

endmodule

// File: tb/tb_exp6_controle_rodadas.sv
// Directed bench for exp6_controle_rodadas: vector table plus game scenarios.
// DUT: N_RODADAS=4, N_CURTO=2, N_VIDAS=3, TIMEOUT_CICLOS=10.
module tb_exp6_controle_rodadas;
    import exp6_controle_rodadas_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       modo;
    logic       jogada;
    logic       igual;
    logic [1:0] endereco;
    logic [1:0] rodada;
    logic       zeraR;
    logic       registraR;
    logic [2:0] vidas;
    logic       acertou;
    logic       errou;
    logic       pronto;
    logic       db_timeout;
    logic [3:0] db_estado;

    int n_ok  = 0;
    int n_tot = 0;
    int reg_seen = 0;
    logic watch = 1'b0;

    int end_i, rod_i, vid_i, fl_i;
    assign end_i = {30'd0, endereco};
    assign rod_i = {30'd0, rodada};
    assign vid_i = {29'd0, vidas};
    // flags: {zeraR, registraR, acertou, errou, db_timeout, pronto}
    assign fl_i  = {26'd0, zeraR, registraR, acertou,
                    errou, db_timeout, pronto};

    always #5 clock = ~clock;

    always @(negedge clock)
        if (watch && registraR) reg_seen <= 1;

    exp6_controle_rodadas #(
        .N_RODADAS      (4),
        .N_CURTO        (2),
        .N_VIDAS        (3),
        .TIMEOUT_CICLOS (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .modo       (modo),
        .jogada     (jogada),
        .igual      (igual),
        .endereco   (endereco),
        .rodada     (rodada),
        .zeraR      (zeraR),
        .registraR  (registraR),
        .vidas      (vidas),
        .acertou    (acertou),
        .errou      (errou),
        .pronto     (pronto),
        .db_timeout (db_timeout),
        .db_estado  (db_estado)
    );

    typedef struct {
        logic    ini, mdo, jog, igu;
        estado_t est;
        int      a, r, v, f;
    } vec_t;

    vec_t tab[16];

    task automatic chk(input string nm, input int got, input int exp);
        n_tot++;
        if (got == exp) n_ok++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    task automatic chk_est(input string nm, input estado_t e);
        n_tot++;
        if (db_estado === e) n_ok++;
        else $display("FAIL %s: db_estado %h, expected %h",
                      nm, db_estado, e);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic start_game(input logic m);
        iniciar = 1'b1;
        modo    = m;
        step();
        iniciar = 1'b0;
        chk_est("start prep", PREPARACAO);
        chk("start prep flags", fl_i, 'b100000);
        step();
        modo = ~m;
        chk_est("start inicio", INICIO_RODADA);
        chk("start vidas", vid_i, 3);
        chk("start rodada", rod_i, 0);
        chk("start endereco", end_i, 0);
        step();
        chk_est("start espera", ESPERA);
    endtask

    task automatic play(input logic ok, input int idle);
        repeat (idle) step();
        if (idle > 0) chk_est("idle espera", ESPERA);
        jogada = 1'b1;
        igual  = ok;
        step();
        jogada = 1'b0;
        chk_est("play registra", REGISTRA);
        chk("play registraR", fl_i, 'b010000);
        step();
        chk_est("play comparacao", COMPARACAO);
        step();
        igual = 1'b0;
    endtask

    task automatic rodada_ok(input int r, input int idle);
        for (int p = 0; p <= r; p++) begin
            chk($sformatf("r%0d p%0d endereco", r, p), end_i, p);
            chk($sformatf("r%0d p%0d rodada", r, p), rod_i, r);
            play(1'b1, idle);
            if (p < r) begin
                chk_est("proxima", PROXIMA_JOGADA);
                step();
            end
        end
    endtask

    task automatic next_round();
        chk_est("fim rodada", FIM_RODADA);
        step();
        chk_est("inicio rodada", INICIO_RODADA);
        step();
    endtask

    initial begin
        // short game (limit 2), modo toggled after latch; iniciar ignored
        tab[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, PREPARACAO,     0, 0, 0, 'b100000};
        tab[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, INICIO_RODADA,  0, 0, 3, 'b100000};
        tab[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, ESPERA,         0, 0, 3, 'b000000};
        tab[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, REGISTRA,       0, 0, 3, 'b010000};
        tab[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, COMPARACAO,     0, 0, 3, 'b000000};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, FIM_RODADA,     0, 0, 3, 'b000000};
        tab[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, INICIO_RODADA,  0, 1, 3, 'b100000};
        tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, ESPERA,         0, 1, 3, 'b000000};
        tab[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, REGISTRA,       0, 1, 3, 'b010000};
        tab[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, COMPARACAO,     0, 1, 3, 'b000000};
        tab[10] = '{1'b1, 1'b0, 1'b0, 1'b1, PROXIMA_JOGADA, 0, 1, 3, 'b000000};
        tab[11] = '{1'b1, 1'b0, 1'b0, 1'b0, ESPERA,         1, 1, 3, 'b000000};
        tab[12] = '{1'b0, 1'b0, 1'b1, 1'b1, REGISTRA,       1, 1, 3, 'b010000};
        tab[13] = '{1'b0, 1'b0, 1'b0, 1'b1, COMPARACAO,     1, 1, 3, 'b000000};
        tab[14] = '{1'b0, 1'b0, 1'b0, 1'b1, FINAL_ACERTO,   1, 1, 3, 'b001001};
        tab[15] = '{1'b0, 1'b0, 1'b0, 1'b0, FINAL_ACERTO,   1, 1, 3, 'b001001};

        reset   = 1'b0;
        iniciar = 1'b0;
        modo    = 1'b0;
        jogada  = 1'b0;
        igual   = 1'b0;
        step();
        step();
        chk_est("reset estado", INICIAL);
        chk("reset flags", fl_i, 0);
        chk("reset vidas", vid_i, 0);
        reset = 1'b1;
        step();
        chk_est("after reset", INICIAL);

        for (int k = 0; k < 16; k++) begin
            iniciar = tab[k].ini;
            modo    = tab[k].mdo;
            jogada  = tab[k].jog;
            igual   = tab[k].igu;
            step();
            chk_est($sformatf("vec%0d estado", k), tab[k].est);
            chk($sformatf("vec%0d endereco", k), end_i, tab[k].a);
            chk($sformatf("vec%0d rodada", k), rod_i, tab[k].r);
            chk($sformatf("vec%0d vidas", k), vid_i, tab[k].v);
            chk($sformatf("vec%0d flags", k), fl_i, tab[k].f);
        end
        iniciar = 1'b0;
        jogada  = 1'b0;
        igual   = 1'b0;

        // normal game, modo flipped to 1 after latch: 10 plays, ends r=3
        start_game(1'b0);
        for (int r = 0; r < 4; r++) begin
            rodada_ok(r, 0);
            if (r < 3) next_round();
        end
        chk_est("normal final", FINAL_ACERTO);
        chk("normal flags", fl_i, 'b001001);
        chk("normal rodada", rod_i, 3);
        chk("normal endereco", end_i, 3);
        step();
        chk_est("normal hold", FINAL_ACERTO);

        // lives: longest legal wait per play, two misses then loss
        start_game(1'b0);
        rodada_ok(0, 8);
        next_round();
        rodada_ok(1, 8);
        next_round();
        chk("r2 endereco", end_i, 0);
        play(1'b1, 8);
        chk_est("r2 proxima", PROXIMA_JOGADA);
        step();
        play(1'b0, 8);
        chk_est("miss1", PERDE_VIDA);
        chk("miss1 vidas before", vid_i, 3);
        step();
        chk_est("miss1 replay", INICIO_RODADA);
        chk("miss1 vidas", vid_i, 2);
        chk("miss1 rodada", rod_i, 2);
        step();
        chk("miss1 endereco", end_i, 0);
        play(1'b0, 0);
        chk_est("miss2", PERDE_VIDA);
        step();
        chk("miss2 vidas", vid_i, 1);
        chk("miss2 rodada", rod_i, 2);
        step();
        chk("miss2 endereco", end_i, 0);
        play(1'b0, 0);
        chk_est("miss3", FINAL_ERRO);
        chk("miss3 flags", fl_i, 'b000101);
        step();
        chk_est("erro hold", FINAL_ERRO);
        chk("erro vidas", vid_i, 1);
        chk("erro rodada", rod_i, 2);

        // timeout: espera lasts exactly 10 cycles
        start_game(1'b0);
        repeat (9) step();
        chk_est("timeout cycle 10", ESPERA);
        step();
        chk_est("timeout", FINAL_TIMEOUT);
        chk("timeout flags", fl_i, 'b000011);

        // play on the timeout cycle loses to timeout
        watch = 1'b1;
        start_game(1'b0);
        repeat (9) step();
        jogada = 1'b1;
        igual  = 1'b1;
        step();
        jogada = 1'b0;
        igual  = 1'b0;
        chk_est("tie timeout", FINAL_TIMEOUT);
        step();
        chk_est("tie hold", FINAL_TIMEOUT);
        watch = 1'b0;
        chk("tie registraR seen", reg_seen, 0);

        // async reset mid-game
        start_game(1'b1);
        rodada_ok(0, 0);
        next_round();
        chk_est("pre reset espera", ESPERA);
        chk("pre reset rodada", rod_i, 1);
        #2 reset = 1'b0;
        #1;
        chk_est("async reset estado", INICIAL);
        chk("async reset flags", fl_i, 0);
        chk("async reset rodada", rod_i, 0);
        chk("async reset vidas", vid_i, 0);
        step();
        reset = 1'b1;
        step();
        chk_est("post reset idle", INICIAL);
        start_game(1'b0);
        rodada_ok(0, 0);
        chk_est("post reset normal limit", FIM_RODADA);

        $display("%0d/%0d checks passed", n_ok, n_tot);
        $finish;
    end

endmodule
